// File: rtl/logic_unit_pipe.sv
// Two-stage pipelined bitwise logic unit (AND/OR/XOR/NOR) with zero flag and output-transfer counter.
// Optional: define LOGIC_PARITY_EN to add a registered XOR-reduce parity output.
module logic_unit_pipe #(
   parameter int WIDTH = 16,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] Rs,
   input  logic [WIDTH-1:0] Rt,
   input  logic [1:0]       op,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] O,
   output logic             zero,
   output logic [CNT_W-1:0] op_count
`ifdef LOGIC_PARITY_EN
   ,
   output logic             parity
`endif
);

   // Handshake: a transfer happens on any rising edge where valid && ready.
   // The producer holds data while valid && !ready; ready never depends on
   // valid of the same interface, but in_ready follows out_ready combinationally.

   localparam logic [1:0] OP_AND = 2'b00;
   localparam logic [1:0] OP_OR  = 2'b01;
   localparam logic [1:0] OP_XOR = 2'b10;

   logic             s1_valid;
   logic             s2_valid;
   logic [WIDTH-1:0] s1_rs;
   logic [WIDTH-1:0] s1_rt;
   logic [1:0]       s1_op;
   logic [WIDTH-1:0] s2_o;
   logic             s2_zero;
   logic [CNT_W-1:0] cnt;
   logic [WIDTH-1:0] result;
   logic             s1_adv;
   logic             s2_adv;
   logic             in_xfer;
   logic             out_xfer;

   assign s2_adv   = !s2_valid || out_ready;
   assign s1_adv   = !s1_valid || s2_adv;
   assign in_ready = s1_adv;
   assign in_xfer  = in_valid && s1_adv;
   assign out_xfer = s2_valid && out_ready;

   always_comb begin
      result = '0;
      case (s1_op)
         OP_AND:  result = s1_rs & s1_rt;
         OP_OR:   result = s1_rs | s1_rt;
         OP_XOR:  result = s1_rs ^ s1_rt;
         default: result = ~(s1_rs | s1_rt);
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid <= 1'b0;
         s2_valid <= 1'b0;
      end else begin
         if (s1_adv) s1_valid <= in_valid;
         if (s2_adv) s2_valid <= s1_valid;
      end
   end

   // Operand registers carry no reset; s1_valid alone qualifies them.
   always_ff @(posedge clk) begin
      if (in_xfer) begin
         s1_rs <= Rs;
         s1_rt <= Rt;
         s1_op <= op;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s2_o    <= '0;
         s2_zero <= 1'b0;
      end else if (s2_adv && s1_valid) begin
         s2_o    <= result;
         s2_zero <= ~|result;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)        cnt <= '0;
      else if (out_xfer) cnt <= cnt + 1'b1;
   end

`ifdef LOGIC_PARITY_EN
   logic s2_parity;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                     s2_parity <= 1'b0;
      else if (s2_adv && s1_valid)    s2_parity <= ^result;
   end

   assign parity = s2_parity;
`endif

   assign out_valid = s2_valid;
   assign O         = s2_o;
   assign zero      = s2_zero;
   assign op_count  = cnt;

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Directed, table-driven bench for logic_unit_pipe (WIDTH=16, CNT_W=4 so the counter wrap is reachable).
module tb_logic_unit_pipe;

   typedef struct {
      logic [15:0] rs;
      logic [15:0] rt;
      logic [1:0]  op;
      logic [15:0] exp_o;
      logic        exp_zero;
   } vec_t;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] Rs;
   logic [15:0] Rt;
   logic [1:0]  op;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] O;
   logic        zero;
   logic [3:0]  op_count;
`ifdef LOGIC_PARITY_EN
   logic        parity;
`endif

   vec_t        vecs [12];
   logic [15:0] cur_o;
   logic        cur_zero;
   logic [16:0] exp_q [$];
   logic [16:0] mon_e;
   int          n_cmp;
   int          n_bad;
   int          n_acc;

   logic_unit_pipe #(.WIDTH(16), .CNT_W(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .Rs        (Rs),
      .Rt        (Rt),
      .op        (op),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .O         (O),
      .zero      (zero),
      .op_count  (op_count)
`ifdef LOGIC_PARITY_EN
      ,
      .parity    (parity)
`endif
   );

   // Clock and reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   // Driver tasks
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input int idx);
      int  k;
      logic acc;
      in_valid = 1'b1;
      Rs       = vecs[idx].rs;
      Rt       = vecs[idx].rt;
      op       = vecs[idx].op;
      cur_o    = vecs[idx].exp_o;
      cur_zero = vecs[idx].exp_zero;
      acc      = 1'b0;
      k        = 0;
      while (!acc && k < 50) begin
         @(negedge clk);
         acc = in_ready;
         step();
         k++;
      end
      if (!acc) check("send_timeout", 32'(acc), 32'd1);
      else      n_acc++;
   endtask

   task automatic drain();
      int k;
      k = 0;
      while (exp_q.size() != 0 && k < 100) begin
         step();
         k++;
      end
      check("drain_empty", 32'(exp_q.size()), 32'd0);
   endtask

   task automatic do_reset(input int cycles);
      in_valid = 1'b0;
      rst_n    = 1'b0;
      repeat (cycles) step();
      exp_q.delete();
      rst_n = 1'b1;
   endtask

   // Scoreboard: push on input transfer, pop and compare on output transfer
   always @(negedge clk) begin
      if (rst_n) begin
         if (in_valid && in_ready) exp_q.push_back({cur_zero, cur_o});
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               n_cmp++;
               n_bad++;
               $display("FAIL unexpected_out: got O=%h want no output", O);
            end else begin
               mon_e = exp_q.pop_front();
               check("mon_O", 32'(O), 32'(mon_e[15:0]));
               check("mon_zero", 32'(zero), 32'(mon_e[16]));
`ifdef LOGIC_PARITY_EN
               check("mon_parity", 32'(parity), 32'(^mon_e[15:0]));
`endif
            end
         end
      end
   end

   initial begin
      vecs[0]  = '{16'hF0F0, 16'hFF00, 2'b00, 16'hF000, 1'b0};
      vecs[1]  = '{16'hF0F0, 16'hFF00, 2'b01, 16'hFFF0, 1'b0};
      vecs[2]  = '{16'hF0F0, 16'hFF00, 2'b10, 16'h0FF0, 1'b0};
      vecs[3]  = '{16'hF0F0, 16'hFF00, 2'b11, 16'h000F, 1'b0};
      vecs[4]  = '{16'h00FF, 16'hFF00, 2'b00, 16'h0000, 1'b1};
      vecs[5]  = '{16'hFFFF, 16'hFFFF, 2'b11, 16'h0000, 1'b1};
      vecs[6]  = '{16'hFFFF, 16'hFFFF, 2'b01, 16'hFFFF, 1'b0};
      vecs[7]  = '{16'h1234, 16'h00FF, 2'b10, 16'h12CB, 1'b0};
      vecs[8]  = '{16'h0007, 16'h0000, 2'b01, 16'h0007, 1'b0};
      vecs[9]  = '{16'hAAAA, 16'h5555, 2'b10, 16'hFFFF, 1'b0};
      vecs[10] = '{16'hAAAA, 16'h5555, 2'b00, 16'h0000, 1'b1};
      vecs[11] = '{16'h8001, 16'h8001, 2'b11, 16'h7FFE, 1'b0};

      n_cmp = 0; n_bad = 0; n_acc = 0;
      in_valid = 1'b0; out_ready = 1'b1;
      Rs = '0; Rt = '0; op = '0; cur_o = '0; cur_zero = 1'b0;

      // Reset then idle
      rst_n = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("rst_out_valid", 32'(out_valid), 32'd0);
         check("rst_in_ready", 32'(in_ready), 32'd1);
         check("rst_op_count", 32'(op_count), 32'd0);
         check("rst_O", 32'(O), 32'd0);
         check("rst_zero", 32'(zero), 32'd0);
         step();
      end
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         check("idle_out_valid", 32'(out_valid), 32'd0);
         check("idle_in_ready", 32'(in_ready), 32'd1);
         check("idle_op_count", 32'(op_count), 32'd0);
      end

      // Op sweep, back-to-back, with latency observed directly
      send(0);
      check("lat_s1_only", 32'(out_valid), 32'd0);
      send(1);
      check("lat_valid", 32'(out_valid), 32'd1);
      check("sweep_and", 32'(O), 32'hF000);
      send(2);
      check("sweep_or", 32'(O), 32'hFFF0);
      send(3);
      check("sweep_xor", 32'(O), 32'h0FF0);
      in_valid = 1'b0;
      step();
      check("sweep_nor", 32'(O), 32'h000F);
      step();
      check("bubble_out_valid", 32'(out_valid), 32'd0);
      check("sweep_count", 32'(op_count), 32'd4);

      // Zero flag (scoreboard checks O and zero)
      for (int i = 4; i <= 6; i++) send(i);
      in_valid = 1'b0;
      drain();
      check("zero_count", 32'(op_count), 32'd7);

      // Backpressure: 5 ops while the consumer stalls
      out_ready = 1'b0;
      n_acc = 0;
      fork
         begin
            for (int i = 7; i <= 11; i++) send(i);
            in_valid = 1'b0;
         end
         begin
            repeat (3) step();
            check("bp_accepted", 32'(n_acc), 32'd2);
            check("bp_in_ready", 32'(in_ready), 32'd0);
            check("bp_out_valid", 32'(out_valid), 32'd1);
            check("bp_O", 32'(O), 32'h12CB);
            repeat (3) step();
            check("bp_hold_accepted", 32'(n_acc), 32'd2);
            check("bp_hold_out_valid", 32'(out_valid), 32'd1);
            check("bp_hold_O", 32'(O), 32'h12CB);
            out_ready = 1'b1;
         end
      join
      drain();
      check("bp_count", 32'(op_count), 32'd12);

      // Reset mid-stream with the pipe full
      out_ready = 1'b0;
      send(0);
      send(1);
      in_valid = 1'b0;
      check("full_in_ready", 32'(in_ready), 32'd0);
      #2;
      rst_n = 1'b0;
      #1;
      check("mid_rst_out_valid", 32'(out_valid), 32'd0);
      check("mid_rst_count", 32'(op_count), 32'd0);
      check("mid_rst_in_ready", 32'(in_ready), 32'd1);
      exp_q.delete();
      step();
      rst_n = 1'b1;
      out_ready = 1'b1;
      send(7);
      in_valid = 1'b0;
      step();
      check("post_rst_valid", 32'(out_valid), 32'd1);
      check("post_rst_O", 32'(O), 32'h12CB);
      check("post_rst_zero", 32'(zero), 32'd0);
      drain();
      check("post_rst_count", 32'(op_count), 32'd1);

      // Counter wrap: 17 transfers on a 4-bit counter, includes the parity vector
      do_reset(2);
      for (int i = 0; i < 17; i++) send(i % 12);
      in_valid = 1'b0;
      drain();
      check("wrap_count", 32'(op_count), 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/logic_unit_pipe.md
Name: logic_unit_pipe

Overview:
- Parametrised, pipelined bitwise logic unit. Successor to the fixed 16-bit single-function OR operator in the MIPS ALU datapath.
- Performs AND/OR/XOR/NOR on WIDTH-bit Rs/Rt operands through a 2-stage registered pipeline with valid/ready handshakes and full backpressure.
- Sits between the register-read stage and the ALU result mux. Also produces a zero flag for branch-compare support.

Parameters:
- WIDTH, 16, operand/result width in bits (>=1).
- CNT_W, 16, width of the completed-operation counter.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  Rs/Rt/op presented.
- in_ready  output  1  unit can accept this cycle.
- Rs  input  WIDTH  operand A.
- Rt  input  WIDTH  operand B.
- op  input  2  00=AND, 01=OR, 10=XOR, 11=NOR.
- out_valid  output  1  O/zero valid.
- out_ready  input  1  consumer accepts.
- O  output  WIDTH  result.
- zero  output  1  1 when O == 0.
- op_count  output  CNT_W  number of completed output transfers.

Behaviour:
- Reset (async assert, sync-release usage assumed by system):
  - s1_valid=0, s2_valid=0, out_valid=0.
  - O=0, zero=0, op_count=0, in_ready=1.
- Transfers:
  - Input transfer when in_valid && in_ready.
  - Output transfer when out_valid && out_ready.
- Stage 1 (S1):
  - Captures Rs, Rt, op on input transfer.
  - Holds its contents while stalled.
- Stage 2 (S2):
  - Registers the computed result f(op, Rs, Rt) and zero = ~|result.
  - Drives O/zero/out_valid directly from registers; no combinational path from Rs/Rt to O.
- Advance rules:
  - s2_adv = !s2_valid || out_ready.
  - s1_adv = !s1_valid || s2_adv.
  - in_ready = s1_adv. This is combinational from out_ready; no skid buffer.
- Latency and throughput:
  - Latency is 2 cycles from input transfer to out_valid when out_ready stays 1.
  - Sustained throughput is 1 op/cycle.
- Data stability: while out_valid && !out_ready, O, zero and out_valid hold stable. No data is lost or duplicated.
- Bubbles:
  - When S1 is empty and s2_adv is true, s2_valid clears on the next edge.
  - When in_valid=0 and S1 is empty, S1 stays empty.
- Simultaneous events:
  - Output transfer and input transfer in the same cycle are both honoured.
  - With the pipe full and out_ready=1, S2 takes S1's contents and S1 takes the new input in the same edge.
- op_count:
  - Increments by 1 on each output transfer.
  - Wraps from 2^CNT_W-1 to 0 with no saturation or flag.
- Width rules: all ops are bitwise over WIDTH bits; there is no carry or sign behaviour. NOR = ~(Rs|Rt) over WIDTH bits.
- Reset mid-operation:
  - Both stages are discarded immediately (asynchronously).
  - out_valid drops the same instant.
  - op_count returns to 0.
  - The first input after deassertion is accepted normally.
- X-safety: op, Rs and Rt are ignored when in_valid=0. Stage data registers need not reset, but out_valid must.

Optional Feature:
- Macro LOGIC_PARITY_EN.
- When defined:
  - Adds output port parity (1 bit) = ^result (XOR-reduce), registered in S2 alongside zero.
  - parity resets to 0 and follows the same hold and advance rules as O.
- When undefined: the parity port and its logic are absent. All other behaviour is identical.

Test Plan:
1. Reset then idle:
   - Stimulus: rst_n=0 for 3 cycles, then release with in_valid=0.
   - Required: out_valid=0, in_ready=1, op_count=0 throughout.
2. Op sweep, WIDTH=16:
   - Stimulus: Rs=16'hF0F0, Rt=16'hFF00 with op=00,01,10,11 back-to-back, out_ready=1.
   - Required: O=16'hF000, 16'hFFF0, 16'h0FF0, 16'h000F on cycles 2,3,4,5 after the first transfer. op_count=4 afterwards.
3. Zero flag:
   - Stimulus: Rs=16'h00FF, Rt=16'hFF00, op=AND.
   - Required: O=0, zero=1. Then op=NOR with Rs=Rt=16'hFFFF gives O=0, zero=1. Then op=OR gives zero=0.
4. Backpressure:
   - Stimulus: stream 5 ops with out_ready=0 for cycles 2-7.
   - Required: in_ready=0 after 2 ops are accepted, O held stable while stalled. All 5 results emerge in order with no loss or duplication once out_ready=1.
5. Reset mid-stream:
   - Stimulus: pipe full, assert rst_n=0 asynchronously between edges.
   - Required: out_valid falls immediately and op_count=0. After release, a new op (Rs=16'h1234, Rt=16'h00FF, XOR) yields O=16'h12CB with zero=0.
6. Counter wrap and parity:
   - Stimulus: CNT_W=4, 17 transfers.
   - Required: op_count=1. With LOGIC_PARITY_EN defined, Rs=16'h0007, Rt=0, OR gives parity=1.
